max_value_tracker: RTL
======================

Name: max_value_tracker

Overview:
- Sits upstream of the command-reader data path in the acoustics capture chain.
- Consumes the demultiplexed ADC sample stream, the selected channel and the programmed threshold.
- Detects the first sample on the armed channel that exceeds the threshold, then tracks the peak over a fixed window of samples.
- Produces the 10-bit max value that the command reader scales and returns to the host.

Parameters:
- SAMPLE_W, 10, ADC sample width in bits (unsigned offset binary)
- THRESH_W, 16, threshold input width
- WINDOW_LEN, 1024, number of armed-channel samples in the capture window, including the trigger sample; legal range 1..65535
- CNT_W, 16, window counter width; must satisfy 2^CNT_W > WINDOW_LEN

Ports:
- clk  in  1  system clock; only clock
- reset  in  1  synchronous, active-high reset
- arm  in  1  single-cycle pulse: latch channel_sel, clear max, enter ARMED
- clear  in  1  single-cycle pulse: abandon any operation, return to IDLE
- channel_sel  in  3  channel to monitor; sampled only on arm
- threshold  in  THRESH_W  trigger level; compared live, not latched
- sample_valid  in  1  qualifies sample_channel/sample_data for one cycle
- sample_channel  in  3  channel index of the current sample
- sample_data  in  SAMPLE_W  sample value
- max_value  out  SAMPLE_W  peak captured in the window
- max_valid  out  1  high while a completed window result is held
- triggered  out  1  high in CAPTURE and DONE
- busy  out  1  high in ARMED and CAPTURE

Behaviour:
- Reset: state IDLE; max_value=0; max_valid=0; triggered=0; busy=0; latched channel=0; counter=0. All outputs are registered.
- Accepted sample: sample_valid=1 and sample_channel equals the latched channel. All other samples are ignored.
- Compare rule: trigger when zero-extended sample_data (to THRESH_W) is strictly greater than threshold. Equal values do not trigger. Thresholds at or above 2^SAMPLE_W never trigger.
- States:
  - IDLE: wait. arm → ARMED.
  - ARMED: on an accepted sample passing the compare → CAPTURE, with max_value=sample and count=1. If WINDOW_LEN=1, go directly to DONE with max_valid=1 on that same edge.
  - CAPTURE: on each accepted sample:
    - max_value = greater of max_value and sample; ties keep the current value.
    - count increments.
    - On the edge accepting the WINDOW_LEN-th sample → DONE, with max_valid=1 visible the following cycle.
  - DONE: hold max_value and max_valid. Ignore samples. arm → ARMED; clear → IDLE.
- arm in any state:
  - Re-latches channel_sel.
  - max_value=0, count=0, max_valid=0.
  - Next state is ARMED, including a restart mid-CAPTURE.
- clear in any state: next state IDLE, max_valid=0, count=0. max_value is retained for debug until the next arm or reset.
- Simultaneous events:
  - reset beats clear; clear beats arm.
  - An arm in the same cycle as an accepted sample discards that sample.
- Counter never wraps: the window ends exactly at WINDOW_LEN.
- Latency: trigger-to-triggered output is 1 cycle. Last-window-sample to max_valid is 1 cycle.

Optional Feature:
- Macro: MAX_TRACKER_PEAK_INDEX_EN
- Defined:
  - Adds output peak_index [CNT_W-1:0]: the window position (0-based, trigger sample = 0) of the sample that last updated max_value.
  - Reset and arm clear it to 0; clear retains it.
  - Ties keep the earlier index.
- Not defined: port absent, no counter-index register; all other behaviour is identical.

Decomposition:
- Shared package acoustics_pkg holds:
  - State encoding enum: IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
  - ADC width constant of 10 and channel width of 3.
  - Default WINDOW_LEN.
- One natural sub-module, max_tracker_window_counter: loadable/clearable up-counter with terminal-count flag at WINDOW_LEN. The rest stays in the top.

Test Plan:
- Reset then idle, samples streaming → max_value=0, max_valid=0, triggered=0, busy=0 throughout.
- arm with channel_sel=2, threshold=16'h0016, WINDOW_LEN=4; channel 2 samples 0x010, 0x016, 0x017, 0x050, 0x3FF, 0x020 (interleaved channel 1 sample 0x3FF ignored) → trigger on 0x017; max_valid one cycle after 0x020 with max_value=0x3FF; peak_index=2 when enabled.
- threshold=16'h0400 with channel 0 samples 0x3FF → never leaves ARMED; busy=1, triggered=0.
- Mid-CAPTURE, arm with channel_sel=5 coincident with an accepted channel-2 sample → ARMED on channel 5, max_value=0, that sample discarded, count restarts.
- clear and arm asserted together in DONE → IDLE, max_valid=0; a separate clear in CAPTURE → IDLE with max_value retained.
- WINDOW_LEN=1 build: single sample 0x200 over threshold 0x100 → DONE on the same edge, max_valid=1 next cycle, max_value=0x200.

Source files
------------

// File: rtl/max_value_tracker_pkg.sv
// Shared acoustics-chain definitions (package acoustics_pkg): tracker state encoding,
// ADC/channel widths and the default capture window length.
package acoustics_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } tracker_state_t;

    localparam int ADC_W              = 10;
    localparam int CHAN_W             = 3;
    localparam int DEFAULT_WINDOW_LEN = 1024;

endpackage

// File: rtl/max_value_tracker_if.sv
// Control, sample-stream and result signals of max_value_tracker.
// Optional peak_index signal present when MAX_TRACKER_PEAK_INDEX_EN is defined.
interface max_value_tracker_if
    import acoustics_pkg::*;
#(
    parameter int SAMPLE_W = ADC_W,
    parameter int THRESH_W = 16,
    parameter int CNT_W    = 16
);
    logic                arm;
    logic                clear;
    logic [CHAN_W-1:0]   channel_sel;
    logic [THRESH_W-1:0] threshold;
    logic                sample_valid;
    logic [CHAN_W-1:0]   sample_channel;
    logic [SAMPLE_W-1:0] sample_data;
    logic [SAMPLE_W-1:0] max_value;
    logic                max_valid;
    logic                triggered;
    logic                busy;
`ifdef MAX_TRACKER_PEAK_INDEX_EN
    logic [CNT_W-1:0]    peak_index;
`endif

    modport master (
        output arm, clear, channel_sel, threshold,
        output sample_valid, sample_channel, sample_data,
        input  max_value, max_valid, triggered, busy
`ifdef MAX_TRACKER_PEAK_INDEX_EN
        , input peak_index
`endif
    );

    modport slave (
        input  arm, clear, channel_sel, threshold,
        input  sample_valid, sample_channel, sample_data,
        output max_value, max_valid, triggered, busy
`ifdef MAX_TRACKER_PEAK_INDEX_EN
        , output peak_index
`endif
    );

endinterface

// File: rtl/max_value_tracker_window_counter.sv
// Window sample counter: clear to 0, load to 1 on the trigger sample, increment on
// each further accepted sample, saturating at WINDOW_LEN (o_terminal).
module max_tracker_window_counter #(
    parameter int WINDOW_LEN = 1024,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count,
    output logic             o_terminal
);

    logic [CNT_W-1:0] r_count;

    assign o_count    = r_count;
    assign o_terminal = (r_count == CNT_W'(WINDOW_LEN));

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= CNT_W'(1);
        end else if (i_inc && !o_terminal) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/max_value_tracker.sv
// Threshold-triggered peak tracker over a window of WINDOW_LEN armed-channel samples.
// Define MAX_TRACKER_PEAK_INDEX_EN to add the peak_index output.
module max_value_tracker
    import acoustics_pkg::*;
#(
    parameter int SAMPLE_W   = ADC_W,
    parameter int THRESH_W   = 16,
    parameter int WINDOW_LEN = DEFAULT_WINDOW_LEN,
    parameter int CNT_W      = 16
) (
    input logic               clk,
    input logic               reset,
    max_value_tracker_if.slave bus
);

    tracker_state_t      r_state;
    tracker_state_t      w_nextState;
    logic [CHAN_W-1:0]   r_channel;
    logic [SAMPLE_W-1:0] r_maxValue;
    logic                r_maxValid;
    logic                r_triggered;
    logic                r_busy;

    logic                w_accept;
    logic                w_aboveThresh;
    logic                w_trigger;
    logic                w_advance;
    logic                w_lastSample;
    logic                w_newPeak;
    logic                w_cntClear;
    logic                w_terminal;
    logic [CNT_W-1:0]    w_count;

    // clear and arm both pre-empt the data path, so a coincident sample is never consumed
    assign w_accept      = bus.sample_valid && (bus.sample_channel == r_channel);
    assign w_aboveThresh = THRESH_W'(bus.sample_data) > bus.threshold;
    assign w_trigger     = !bus.clear && !bus.arm && (r_state == ARMED) && w_accept && w_aboveThresh;
    assign w_advance     = !bus.clear && !bus.arm && (r_state == CAPTURE) && w_accept && !w_terminal;
    assign w_lastSample  = (w_count == CNT_W'(WINDOW_LEN - 1));
    assign w_newPeak     = bus.sample_data > r_maxValue;
    assign w_cntClear    = bus.clear || bus.arm;

    max_tracker_window_counter #(
        .WINDOW_LEN (WINDOW_LEN),
        .CNT_W      (CNT_W)
    ) u_windowCounter (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_cntClear),
        .i_load     (w_trigger),
        .i_inc      (w_advance),
        .o_count    (w_count),
        .o_terminal (w_terminal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        if (bus.clear) begin
            w_nextState = IDLE;
        end else if (bus.arm) begin
            w_nextState = ARMED;
        end else if (w_trigger) begin
            w_nextState = (WINDOW_LEN == 1) ? DONE : CAPTURE;
        end else if (w_advance && w_lastSample) begin
            w_nextState = DONE;
        end
    end

    // Status flags are registered decodes of the next state so they track r_state exactly
    always_ff @(posedge clk) begin
        if (reset) begin
            r_channel   <= '0;
            r_maxValue  <= '0;
            r_maxValid  <= 1'b0;
            r_triggered <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_maxValid  <= (w_nextState == DONE);
            r_triggered <= (w_nextState == CAPTURE) || (w_nextState == DONE);
            r_busy      <= (w_nextState == ARMED) || (w_nextState == CAPTURE);
            if (!bus.clear) begin
                if (bus.arm) begin
                    r_channel  <= bus.channel_sel;
                    r_maxValue <= '0;
                end else if (w_trigger) begin
                    r_maxValue <= bus.sample_data;
                end else if (w_advance && w_newPeak) begin
                    r_maxValue <= bus.sample_data;
                end
            end
        end
    end

`ifdef MAX_TRACKER_PEAK_INDEX_EN
    logic [CNT_W-1:0] r_peakIndex;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_peakIndex <= '0;
        end else if (!bus.clear) begin
            if (bus.arm || w_trigger) begin
                r_peakIndex <= '0;
            end else if (w_advance && w_newPeak) begin
                r_peakIndex <= w_count;
            end
        end
    end

    assign bus.peak_index = r_peakIndex;
`endif

    assign bus.max_value = r_maxValue;
    assign bus.max_valid = r_maxValid;
    assign bus.triggered = r_triggered;
    assign bus.busy      = r_busy;

endmodule
